// File: rtl/fifo_read_checker.sv
// fifo_read_checker: read-side FIFO drain that checks each popped word against a regenerated sequence.
// Define FIFO_READ_CHECKER_LFSR_EN to use an LFSR expected sequence instead of an incrementing one.
module fifo_read_checker #(
    parameter int DSIZE = 16,
    parameter int SEED  = 0,
    parameter int GAPW  = 4,
    parameter int CNTW  = 32
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic [GAPW-1:0]  gap_i,
    input  logic             rempty_i,
    input  logic [DSIZE-1:0] rdata_i,
    output logic             rinc_o,
    output logic [CNTW-1:0]  nwords_o,
    output logic [CNTW-1:0]  nerr_o,
    output logic             err_o,
    output logic [DSIZE-1:0] first_exp_o,
    output logic [DSIZE-1:0] first_got_o
);
    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;
`ifdef FIFO_READ_CHECKER_LFSR_EN
    localparam logic [DSIZE-1:0] TAPS  = DSIZE'(16'hB400);
    // An all-zero LFSR never leaves zero, so a zero seed starts at 1.
    localparam logic [DSIZE-1:0] START = (SEED == 0) ? DSIZE'(1) : DSIZE'(SEED);
`else
    localparam logic [DSIZE-1:0] START = DSIZE'(SEED);
`endif
    state_t           state;
    logic [GAPW-1:0]  gap_cnt;
    logic [DSIZE-1:0] exp_q;
    logic [DSIZE-1:0] exp_nxt;
    logic             mismatch;
    always_comb begin
        rinc_o   = enable_i && !restart_i && state == READ && !rempty_i;
        mismatch = rinc_o && rdata_i != exp_q;
`ifdef FIFO_READ_CHECKER_LFSR_EN
        exp_nxt  = {exp_q[DSIZE-2:0], ^(exp_q & TAPS)};
`else
        exp_nxt  = exp_q + 1'b1;
`endif
    end
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            exp_q       <= START;
            nwords_o    <= '0;
            nerr_o      <= '0;
            err_o       <= 1'b0;
            first_exp_o <= '0;
            first_got_o <= '0;
        end else if (restart_i) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            exp_q       <= START;
            nwords_o    <= '0;
            nerr_o      <= '0;
            err_o       <= 1'b0;
            first_exp_o <= '0;
            first_got_o <= '0;
        end else begin
            // Expected advances from itself, never from rdata_i, so a lost word keeps failing.
            if (rinc_o) begin
                nwords_o <= nwords_o + 1'b1;
                exp_q    <= exp_nxt;
            end
            if (mismatch) begin
                nerr_o <= (&nerr_o) ? nerr_o : nerr_o + 1'b1;
                if (!err_o) begin
                    err_o       <= 1'b1;
                    first_exp_o <= exp_q;
                    first_got_o <= rdata_i;
                end
            end
            if (!enable_i)
                state <= IDLE;
            else
                case (state)
                    IDLE: state <= READ;
                    READ: if (rinc_o && gap_i != '0) begin
                        gap_cnt <= gap_i;
                        state   <= GAP;
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAPW'(1)) state <= READ;
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_checker.sv
// tb_fifo_read_checker: randomized FIFO-source bench with a queue-based reference for fifo_read_checker.
// Honours FIFO_READ_CHECKER_LFSR_EN to pick the expected sequence rule.
`timescale 1ns/1ps
module tb_fifo_read_checker;
    logic        rclk = 0, rrst_n = 0, enable_i = 0, restart_i = 0, rempty_i = 1;
    logic [3:0]  gap_i = 0;
    logic [15:0] rdata_i = 0;
    logic        rinc_o, err_o, w_rinc, w_err;
    logic [31:0] nwords_o, nerr_o, w_nwords, w_nerr;
    logic [15:0] first_exp_o, first_got_o, w_first_exp, w_first_got;
    int          n_checks = 0, n_fail = 0, cyc = 0;
    logic        pop = 0, stall = 0;
    logic [15:0] fifo_q[$];
    always #5 rclk = ~rclk;
    fifo_read_checker #(.DSIZE(16), .SEED(0), .GAPW(4), .CNTW(32)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable_i(enable_i), .restart_i(restart_i), .gap_i(gap_i),
        .rempty_i(rempty_i), .rdata_i(rdata_i), .rinc_o(rinc_o), .nwords_o(nwords_o), .nerr_o(nerr_o),
        .err_o(err_o), .first_exp_o(first_exp_o), .first_got_o(first_got_o));
    // Second instance sees the same traffic but starts near the top of the 16-bit range.
    fifo_read_checker #(.DSIZE(16), .SEED(16'hFFFE), .GAPW(4), .CNTW(32)) u_wrap (
        .rclk(rclk), .rrst_n(rrst_n), .enable_i(enable_i), .restart_i(restart_i), .gap_i(gap_i),
        .rempty_i(rempty_i), .rdata_i(rdata_i), .rinc_o(w_rinc), .nwords_o(w_nwords), .nerr_o(w_nerr),
        .err_o(w_err), .first_exp_o(w_first_exp), .first_got_o(w_first_got));
    function automatic logic [15:0] first_of(input logic [15:0] s);
`ifdef FIFO_READ_CHECKER_LFSR_EN
        return (s == 16'h0) ? 16'h1 : s;
`else
        return s;
`endif
    endfunction
    function automatic logic [15:0] nxt(input logic [15:0] e);
`ifdef FIFO_READ_CHECKER_LFSR_EN
        return {e[14:0], e[15] ^ e[13] ^ e[12] ^ e[10]};
`else
        return 16'((32'(e) + 1) % 65536);
`endif
    endfunction
    task automatic step();
        rempty_i = stall || fifo_q.size() == 0;
        rdata_i  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
        #2;
        pop = rinc_o;
        if (pop) begin
            n_checks++;
            if (rempty_i || !enable_i || restart_i) begin n_fail++; $display("FAIL pop_guard got rinc=1 with empty=%0b en=%0b restart=%0b, want rinc=0", rempty_i, enable_i, restart_i); end
        end
        @(posedge rclk); #1;
        if (pop) void'(fifo_q.pop_front());
        cyc++;
        @(negedge rclk);
    endtask
    task automatic do_restart();
        fifo_q.delete();
        restart_i = 1; step(); restart_i = 0;
    endtask
    task automatic drain(input int bound);
        for (int i = 0; i < bound && fifo_q.size() != 0; i++) step();
        n_checks++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL drain_timeout got %0d words left, want 0", fifo_q.size()); end
    endtask
    task automatic test_reset();
        n_checks++; if (rinc_o !== 1'b0) begin n_fail++; $display("FAIL reset_rinc got %0b want 0", rinc_o); end
        n_checks++; if (nwords_o !== 32'd0) begin n_fail++; $display("FAIL reset_nwords got %0d want 0", nwords_o); end
        n_checks++; if (nerr_o !== 32'd0) begin n_fail++; $display("FAIL reset_nerr got %0d want 0", nerr_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_o); end
        n_checks++; if (first_exp_o !== 16'h0 || first_got_o !== 16'h0) begin n_fail++; $display("FAIL reset_capture got %h/%h want 0000/0000", first_exp_o, first_got_o); end
        rrst_n = 1;
        @(negedge rclk);
        n_checks++; if (nwords_o !== 32'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_release got nwords=%0d err=%0b want 0/0", nwords_o, err_o); end
    endtask
    task automatic test_sequence();
        int first = -1, last = -1, n = 0;
        logic [15:0] e;
        enable_i = 1; gap_i = 0; do_restart();
        e = first_of(16'h0);
        for (int k = 0; k < 256; k++) begin fifo_q.push_back(e); e = nxt(e); end
        for (int i = 0; i < 400 && fifo_q.size() != 0; i++) begin
            step();
            if (pop) begin if (first < 0) first = cyc; last = cyc; n++; end
        end
        n_checks++; if (n != 256 || last - first + 1 != 256) begin n_fail++; $display("FAIL seq_burst got %0d pops over %0d cycles, want 256 over 256", n, last - first + 1); end
        n_checks++; if (nwords_o !== 32'd256) begin n_fail++; $display("FAIL seq_nwords got %0d want 256", nwords_o); end
        n_checks++; if (nerr_o !== 32'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL seq_errors got nerr=%0d err=%0b want 0/0", nerr_o, err_o); end
    endtask
    task automatic test_corruption();
        logic [15:0] e, e5;
        do_restart();
        e = first_of(16'h0); e5 = 16'h0;
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin fifo_q.push_back(16'hDEAD); e5 = e; end else fifo_q.push_back(e);
            e = nxt(e);
        end
        drain(100);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL corrupt_err got %0b want 1", err_o); end
        n_checks++; if (first_exp_o !== e5) begin n_fail++; $display("FAIL corrupt_first_exp got %h want %h", first_exp_o, e5); end
        n_checks++; if (first_got_o !== 16'hDEAD) begin n_fail++; $display("FAIL corrupt_first_got got %h want dead", first_got_o); end
        n_checks++; if (nerr_o !== 32'd1 || nwords_o !== 32'd16) begin n_fail++; $display("FAIL corrupt_counts got nerr=%0d nwords=%0d want 1/16", nerr_o, nwords_o); end
    endtask
    task automatic test_throttle();
        int first = -1, last = -1, n = 0;
        logic [15:0] e;
        do_restart(); gap_i = 3;
        e = first_of(16'h0);
        for (int k = 0; k < 100; k++) begin fifo_q.push_back(e); e = nxt(e); end
        for (int i = 0; i < 600 && fifo_q.size() != 0; i++) begin
            step();
            if (pop) begin
                if (last >= 0) begin
                    n_checks++; if (cyc - last != 4) begin n_fail++; $display("FAIL throttle_interval got %0d cycles want 4", cyc - last); end
                end
                if (first < 0) first = cyc;
                last = cyc; n++;
            end
        end
        gap_i = 0;
        n_checks++; if (n != 100 || last - first + 1 != 397) begin n_fail++; $display("FAIL throttle_span got %0d pops over %0d cycles, want 100 over 397", n, last - first + 1); end
        n_checks++; if (nwords_o !== 32'd100 || nerr_o !== 32'd0) begin n_fail++; $display("FAIL throttle_counts got nwords=%0d nerr=%0d want 100/0", nwords_o, nerr_o); end
    endtask
    task automatic test_empty_wrap();
        logic [15:0] e;
        int t;
        do_restart(); gap_i = 0;
        e = first_of(16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            stall = 0; fifo_q.push_back(e); e = nxt(e);
            t = 0;
            while (fifo_q.size() != 0 && t < 20) begin step(); t++; end
            n_checks++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL wrap_pop_timeout got no pop for word %0d want pop", k); end
            stall = 1;
            for (int i = 0; i < 5; i++) begin
                step();
                n_checks++; if (pop) begin n_fail++; $display("FAIL wrap_empty_pop got rinc=1 want 0"); end
            end
        end
        stall = 0;
        n_checks++; if (w_nwords !== 32'd3) begin n_fail++; $display("FAIL wrap_nwords got %0d want 3", w_nwords); end
        n_checks++; if (w_nerr !== 32'd0 || w_err !== 1'b0) begin n_fail++; $display("FAIL wrap_errors got nerr=%0d err=%0b want 0/0", w_nerr, w_err); end
    endtask
    task automatic test_restart();
        logic [15:0] e;
        int n = 0;
        do_restart(); gap_i = 0;
        e = first_of(16'h0);
        for (int k = 0; k < 20; k++) begin fifo_q.push_back(e); e = nxt(e); end
        for (int i = 0; i < 50 && n < 10; i++) begin step(); if (pop) n++; end
        n_checks++; if (nwords_o !== 32'd10) begin n_fail++; $display("FAIL restart_pre_nwords got %0d want 10", nwords_o); end
        restart_i = 1; step(); restart_i = 0;
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL restart_pop got rinc=%0b want 0", pop); end
        n_checks++; if (nwords_o !== 32'd0 || nerr_o !== 32'd0) begin n_fail++; $display("FAIL restart_clear got nwords=%0d nerr=%0d want 0/0", nwords_o, nerr_o); end
        fifo_q.delete();
        e = first_of(16'h0);
        for (int k = 0; k < 5; k++) begin fifo_q.push_back(e); e = nxt(e); end
        drain(50);
        n_checks++; if (nwords_o !== 32'd5 || nerr_o !== 32'd0) begin n_fail++; $display("FAIL restart_reseed got nwords=%0d nerr=%0d want 5/0", nwords_o, nerr_o); end
    endtask
    task automatic test_reset_mid_gap();
        logic [15:0] e;
        int t = 0;
        do_restart(); gap_i = 5;
        e = first_of(16'h0);
        fifo_q.push_back(e ^ 16'h0100); fifo_q.push_back(nxt(e));
        while (fifo_q.size() == 2 && t < 10) begin step(); t++; end
        step();
        n_checks++; if (nwords_o !== 32'd1 || err_o !== 1'b1) begin n_fail++; $display("FAIL gap_pre got nwords=%0d err=%0b want 1/1", nwords_o, err_o); end
        rrst_n = 0; #1;
        n_checks++; if (rinc_o !== 1'b0 || nwords_o !== 32'd0 || nerr_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_counts got rinc=%0b nwords=%0d nerr=%0d want 0/0/0", rinc_o, nwords_o, nerr_o); end
        n_checks++; if (err_o !== 1'b0 || first_exp_o !== 16'h0 || first_got_o !== 16'h0) begin n_fail++; $display("FAIL async_reset_capture got err=%0b exp=%h got=%h want 0/0000/0000", err_o, first_exp_o, first_got_o); end
        @(negedge rclk);
        rrst_n = 1; gap_i = 0; fifo_q.delete();
    endtask
    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int nc = 0, prev = -1, pgap = 0;
            logic en_ok;
            logic [15:0] e, d, fexp, fgot;
            fexp = 16'h0; fgot = 16'h0; en_ok = 1'b1;
            enable_i = 1; gap_i = 0; do_restart();
            e = first_of(16'h0);
            for (int k = 0; k < 40; k++) begin
                d = e;
                if ($urandom_range(0, 7) == 0) begin
                    d = e ^ 16'($urandom_range(1, 65535));
                    if (nc == 0) begin fexp = e; fgot = d; end
                    nc++;
                end
                fifo_q.push_back(d); e = nxt(e);
            end
            for (int i = 0; i < 3000 && fifo_q.size() != 0; i++) begin
                stall = ($urandom_range(0, 3) == 0);
                gap_i = 4'($urandom_range(0, 3));
                enable_i = ($urandom_range(0, 9) != 0);
                if (!enable_i) en_ok = 1'b0;
                step();
                if (pop) begin
                    if (prev >= 0 && en_ok) begin
                        n_checks++; if (cyc - prev < pgap + 1) begin n_fail++; $display("FAIL rand_gap got %0d cycles want >= %0d", cyc - prev, pgap + 1); end
                    end
                    prev = cyc; pgap = int'(gap_i); en_ok = 1'b1;
                end
            end
            stall = 0; enable_i = 1; gap_i = 0;
            n_checks++; if (fifo_q.size() != 0 || nwords_o !== 32'd40) begin n_fail++; $display("FAIL rand_nwords got %0d (left %0d) want 40", nwords_o, fifo_q.size()); end
            n_checks++; if (nerr_o !== 32'(nc) || err_o !== (nc != 0)) begin n_fail++; $display("FAIL rand_nerr got nerr=%0d err=%0b want %0d/%0b", nerr_o, err_o, nc, nc != 0); end
            n_checks++; if (first_exp_o !== fexp || first_got_o !== fgot) begin n_fail++; $display("FAIL rand_capture got %h/%h want %h/%h", first_exp_o, first_got_o, fexp, fgot); end
        end
    endtask
`ifdef FIFO_READ_CHECKER_LFSR_EN
    task automatic test_lfsr();
        do_restart(); gap_i = 0;
        fifo_q.push_back(16'h0001); fifo_q.push_back(16'h0002); fifo_q.push_back(16'h0004); fifo_q.push_back(16'h0008);
        drain(50);
        n_checks++; if (nerr_o !== 32'd0 || nwords_o !== 32'd4) begin n_fail++; $display("FAIL lfsr_match got nerr=%0d nwords=%0d want 0/4", nerr_o, nwords_o); end
        do_restart();
        fifo_q.push_back(16'h0001); fifo_q.push_back(16'h0002); fifo_q.push_back(16'h0003);
        drain(50);
        n_checks++; if (err_o !== 1'b1 || nerr_o !== 32'd1) begin n_fail++; $display("FAIL lfsr_err got err=%0b nerr=%0d want 1/1", err_o, nerr_o); end
        n_checks++; if (first_exp_o !== 16'h0004 || first_got_o !== 16'h0003) begin n_fail++; $display("FAIL lfsr_capture got %h/%h want 0004/0003", first_exp_o, first_got_o); end
    endtask
`endif
    initial begin
        repeat (2) @(negedge rclk);
        test_reset();
        test_sequence();
        test_corruption();
        test_throttle();
        test_empty_wrap();
        test_restart();
        test_reset_mid_gap();
        test_random();
`ifdef FIFO_READ_CHECKER_LFSR_EN
        test_lfsr();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
